// File: rtl/frame_pipe_pkg.sv
// Shared types and constants for the frame buffer pipeline sequencer.
package frame_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FILLED    = 2'd1,
        PROCESSED = 2'd2
    } buf_state_t;

    localparam logic [2:0] CMD_HDR = 3'b100;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_CMD   = 2'd1;
    localparam logic [1:0] W_XFER  = 2'd2;
    localparam logic [1:0] W_GAP   = 2'd3;

    localparam logic [1:0] A_IDLE  = 2'd0;
    localparam logic [1:0] A_START = 2'd1;
    localparam logic [1:0] A_WAIT  = 2'd2;

    localparam logic [1:0] HS_IDLE = 2'd0;
    localparam logic [1:0] HS_REQ  = 2'd1;
    localparam logic [1:0] HS_WAIT = 2'd2;

    // Remote-camera trigger word: header, trigger bit, reserved byte, buffer index, one frame.
    function automatic logic [63:0] remote_cmd(input logic [19:0] idx);
        return {CMD_HDR, 1'b1, 8'h00, idx, 32'h0000_0001};
    endfunction

endpackage

// File: rtl/frame_pipe_hs_stage.sv
// Start/finish handshake for one DDR engine with a sticky wait timeout.
//  state   | meaning
//  HS_IDLE | waiting for go_i from the owning stage
//  HS_REQ  | start/valid high until ready sampled
//  HS_WAIT | finish_ready high, timeout counter running
module frame_pipe_hs_stage
    import frame_pipe_pkg::*;
#(
    parameter int TIMEOUT_W = 24
)(
    input  logic clk,
    input  logic aresetn,
    input  logic go_i,
    input  logic start_ready_i,
    input  logic finish_i,
    input  logic finish_valid_i,
    output logic start_o,
    output logic finish_ready_o,
    output logic done_o,
    output logic idle_o,
    output logic timeout_o
);

    logic [1:0]           state_q, state_d;
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 timeout_q;
    logic                 tmo_hit;

    assign tmo_hit = (state_q == HS_WAIT) && (tmo_cnt_q == '1);

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = '0;
        case (state_q)
            HS_IDLE: if (go_i) state_d = HS_REQ;
            HS_REQ:  if (start_ready_i) state_d = HS_WAIT;
            HS_WAIT: begin
                if (finish_i && finish_valid_i) state_d = HS_IDLE;
                else tmo_cnt_d = tmo_hit ? tmo_cnt_q : tmo_cnt_q + TIMEOUT_W'(1);
            end
            default: state_d = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= HS_IDLE;
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_q | tmo_hit;
        end
    end

    assign start_o        = (state_q == HS_REQ);
    assign finish_ready_o = (state_q == HS_WAIT);
    assign done_o         = finish_ready_o && finish_i && finish_valid_i;
    assign idle_o         = (state_q == HS_IDLE);
    assign timeout_o      = timeout_q;

endmodule

// File: rtl/frame_pipe_ctrl.sv
// Camera -> accelerator -> monitor sequencer rotating over NUM_BUF frame buffers.
// Define ACCEL_BYPASS_EN to remove the accelerator stage (captures go straight to readout).
//  state  | meaning
//  W_IDLE | wait for run and an EMPTY buffer at wr pointer
//  W_CMD  | wait for room in the remote cmd FIFO, pulse cmd_out_wr
//  W_XFER | capture handshake (REQ/WAIT) in u_wr_hs
//  W_GAP  | GAP_CYCLES idle cycles before the next launch
//  A_IDLE | wait for a FILLED buffer at acc pointer
//  A_START| one-cycle acc_start
//  A_WAIT | wait for acc_finish, timeout counter running
module frame_pipe_ctrl
    import frame_pipe_pkg::*;
#(
    parameter int  NUM_BUF    = 2,
    parameter int  GAP_CYCLES = 10,
    parameter int  TIMEOUT_W  = 24,
    localparam int IDX_W      = $clog2(NUM_BUF)
)(
    input  logic             clk,
    input  logic             aresetn,
    input  logic             start_all,
    input  logic             cont_mode,
    output logic             ddr_write_start,
    output logic             ddr_write_start_valid,
    input  logic             ddr_write_start_ready,
    output logic [IDX_W-1:0] write_buf_idx,
    input  logic             ddr_write_finish,
    input  logic             ddr_write_finish_valid,
    output logic             ddr_write_finish_ready,
    output logic             acc_start,
    output logic [IDX_W-1:0] acc_buf_idx,
    input  logic             acc_finish,
    output logic             ddr_read_start,
    output logic             ddr_read_start_valid,
    input  logic             ddr_read_start_ready,
    output logic [IDX_W-1:0] read_buf_idx,
    input  logic             ddr_read_finish,
    input  logic             ddr_read_finish_valid,
    output logic             ddr_read_finish_ready,
    output logic             cmd_out_wr,
    output logic [63:0]      cmd_out,
    input  logic             cmd_out_alf,
    output logic [2:0]       timeout_err,
    output logic             odd_even_flag,
    output logic [31:0]      frame_cnt,
    output logic             busy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [1:0]       w_state_q, w_state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             run_q, run_d;
    logic [31:0]      frame_cnt_q, frame_cnt_d;
    logic             odd_even_q, odd_even_d;
    buf_state_t       buf_q [NUM_BUF];
    buf_state_t       buf_d [NUM_BUF];
    logic             w_launch, w_go, w_done, w_tmo, w_start;
    logic             r_go, r_done, r_idle, r_tmo, r_start;
    logic             a_done, a_busy, a_tmo;
    logic             unused_w_hs_idle;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_BUF - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    assign w_launch = (w_state_q == W_IDLE) && run_q && (buf_q[wr_ptr_q] == EMPTY);
    assign w_go     = (w_state_q == W_CMD) && !cmd_out_alf;

    always_comb begin
        w_state_d = w_state_q;
        gap_d     = gap_q;
        case (w_state_q)
            W_IDLE: if (w_launch) w_state_d = W_CMD;
            W_CMD:  if (w_go) w_state_d = W_XFER;
            W_XFER: begin
                if (w_done) begin
                    w_state_d = W_GAP;
                    gap_d     = GAP_W'(GAP_CYCLES - 1);
                end
            end
            default: begin
                if (gap_q == '0) w_state_d = W_IDLE;
                else gap_d = gap_q - GAP_W'(1);
            end
        endcase
    end

    // A start_all while armed is dropped; single-shot disarms as soon as the capture launches.
    always_comb begin
        run_d = run_q;
        if (!run_q && start_all) run_d = 1'b1;
        else if (w_launch && !cont_mode) run_d = 1'b0;
    end

    frame_pipe_hs_stage #(.TIMEOUT_W(TIMEOUT_W)) u_wr_hs (
        .clk            (clk),
        .aresetn        (aresetn),
        .go_i           (w_go),
        .start_ready_i  (ddr_write_start_ready),
        .finish_i       (ddr_write_finish),
        .finish_valid_i (ddr_write_finish_valid),
        .start_o        (w_start),
        .finish_ready_o (ddr_write_finish_ready),
        .done_o         (w_done),
        .idle_o         (unused_w_hs_idle),
        .timeout_o      (w_tmo)
    );

    assign r_go = r_idle && (buf_q[rd_ptr_q] == PROCESSED);

    frame_pipe_hs_stage #(.TIMEOUT_W(TIMEOUT_W)) u_rd_hs (
        .clk            (clk),
        .aresetn        (aresetn),
        .go_i           (r_go),
        .start_ready_i  (ddr_read_start_ready),
        .finish_i       (ddr_read_finish),
        .finish_valid_i (ddr_read_finish_valid),
        .start_o        (r_start),
        .finish_ready_o (ddr_read_finish_ready),
        .done_o         (r_done),
        .idle_o         (r_idle),
        .timeout_o      (r_tmo)
    );

`ifdef ACCEL_BYPASS_EN
    localparam buf_state_t WR_MARK = PROCESSED;
    logic unused_acc_finish;

    assign unused_acc_finish = acc_finish;
    assign a_done            = 1'b0;
    assign a_busy            = 1'b0;
    assign a_tmo             = 1'b0;
    assign acc_start         = 1'b0;
    assign acc_buf_idx       = '0;
`else
    localparam buf_state_t WR_MARK = FILLED;
    logic [1:0]           a_state_q, a_state_d;
    logic [IDX_W-1:0]     acc_ptr_q, acc_ptr_d;
    logic [TIMEOUT_W-1:0] a_cnt_q, a_cnt_d;
    logic                 a_tmo_q, a_hit;

    assign a_hit  = (a_state_q == A_WAIT) && (a_cnt_q == '1);
    assign a_done = (a_state_q == A_WAIT) && acc_finish;

    always_comb begin
        a_state_d = a_state_q;
        acc_ptr_d = acc_ptr_q;
        a_cnt_d   = '0;
        case (a_state_q)
            A_IDLE:  if (buf_q[acc_ptr_q] == FILLED) a_state_d = A_START;
            A_START: a_state_d = A_WAIT;
            A_WAIT: begin
                if (acc_finish) begin
                    a_state_d = A_IDLE;
                    acc_ptr_d = next_idx(acc_ptr_q);
                end else begin
                    a_cnt_d = a_hit ? a_cnt_q : a_cnt_q + TIMEOUT_W'(1);
                end
            end
            default: a_state_d = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            a_state_q <= A_IDLE;
            acc_ptr_q <= '0;
            a_cnt_q   <= '0;
            a_tmo_q   <= 1'b0;
        end else begin
            a_state_q <= a_state_d;
            acc_ptr_q <= acc_ptr_d;
            a_cnt_q   <= a_cnt_d;
            a_tmo_q   <= a_tmo_q | a_hit;
        end
    end

    assign a_busy      = (a_state_q != A_IDLE);
    assign a_tmo       = a_tmo_q;
    assign acc_start   = (a_state_q == A_START);
    assign acc_buf_idx = acc_ptr_q;
`endif

    // Each stage only ever touches the buffer at its own pointer, so all updates can commit together.
    always_comb begin
        buf_d = buf_q;
        if (w_done) buf_d[wr_ptr_q] = WR_MARK;
`ifndef ACCEL_BYPASS_EN
        if (a_done) buf_d[acc_ptr_q] = PROCESSED;
`endif
        if (r_done) buf_d[rd_ptr_q] = EMPTY;
    end

    assign wr_ptr_d    = w_done ? next_idx(wr_ptr_q) : wr_ptr_q;
    assign rd_ptr_d    = r_done ? next_idx(rd_ptr_q) : rd_ptr_q;
    assign frame_cnt_d = r_done ? frame_cnt_q + 32'd1 : frame_cnt_q;
    assign odd_even_d  = odd_even_q ^ r_done;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q   <= W_IDLE;
            gap_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            run_q       <= 1'b0;
            frame_cnt_q <= '0;
            odd_even_q  <= 1'b0;
            for (int i = 0; i < NUM_BUF; i++) buf_q[i] <= EMPTY;
        end else begin
            w_state_q   <= w_state_d;
            gap_q       <= gap_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            run_q       <= run_d;
            frame_cnt_q <= frame_cnt_d;
            odd_even_q  <= odd_even_d;
            buf_q       <= buf_d;
        end
    end

    assign ddr_write_start       = w_start;
    assign ddr_write_start_valid = w_start;
    assign write_buf_idx         = wr_ptr_q;
    assign ddr_read_start        = r_start;
    assign ddr_read_start_valid  = r_start;
    assign read_buf_idx          = rd_ptr_q;
    assign cmd_out_wr            = w_go;
    assign cmd_out               = w_go ? remote_cmd(20'(wr_ptr_q)) : 64'd0;
    assign timeout_err           = {r_tmo, a_tmo, w_tmo};
    assign odd_even_flag         = odd_even_q;
    assign frame_cnt             = frame_cnt_q;
    assign busy                  = run_q || (w_state_q != W_IDLE) || a_busy || !r_idle;

endmodule

// File: tb/tb_frame_pipe_ctrl.sv
// Directed bench for frame_pipe_ctrl with three buffers, short gap and a 4-bit timeout.
module tb_frame_pipe_ctrl;

    localparam int NB = 3;
    localparam int IW = $clog2(NB);

    logic          clk;
    logic          aresetn;
    logic          start_all, cont_mode;
    logic          ddr_write_start, ddr_write_start_valid, ddr_write_start_ready;
    logic [IW-1:0] write_buf_idx;
    logic          ddr_write_finish, ddr_write_finish_valid, ddr_write_finish_ready;
    logic          acc_start;
    logic [IW-1:0] acc_buf_idx;
    logic          acc_finish;
    logic          ddr_read_start, ddr_read_start_valid, ddr_read_start_ready;
    logic [IW-1:0] read_buf_idx;
    logic          ddr_read_finish, ddr_read_finish_valid, ddr_read_finish_ready;
    logic          cmd_out_wr;
    logic [63:0]   cmd_out;
    logic          cmd_out_alf;
    logic [2:0]    timeout_err;
    logic          odd_even_flag;
    logic [31:0]   frame_cnt;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cmd_cnt;
    int acc_total = 0;
    logic [19:0] cmd_log [8];

    frame_pipe_ctrl #(.NUM_BUF(NB), .GAP_CYCLES(4), .TIMEOUT_W(4)) dut (
        .clk                    (clk),
        .aresetn                (aresetn),
        .start_all              (start_all),
        .cont_mode              (cont_mode),
        .ddr_write_start        (ddr_write_start),
        .ddr_write_start_valid  (ddr_write_start_valid),
        .ddr_write_start_ready  (ddr_write_start_ready),
        .write_buf_idx          (write_buf_idx),
        .ddr_write_finish       (ddr_write_finish),
        .ddr_write_finish_valid (ddr_write_finish_valid),
        .ddr_write_finish_ready (ddr_write_finish_ready),
        .acc_start              (acc_start),
        .acc_buf_idx            (acc_buf_idx),
        .acc_finish             (acc_finish),
        .ddr_read_start         (ddr_read_start),
        .ddr_read_start_valid   (ddr_read_start_valid),
        .ddr_read_start_ready   (ddr_read_start_ready),
        .read_buf_idx           (read_buf_idx),
        .ddr_read_finish        (ddr_read_finish),
        .ddr_read_finish_valid  (ddr_read_finish_valid),
        .ddr_read_finish_ready  (ddr_read_finish_ready),
        .cmd_out_wr             (cmd_out_wr),
        .cmd_out                (cmd_out),
        .cmd_out_alf            (cmd_out_alf),
        .timeout_err            (timeout_err),
        .odd_even_flag          (odd_even_flag),
        .frame_cnt              (frame_cnt),
        .busy                   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture log of remote triggers; cleared while reset is held.
    always @(negedge clk) begin
        if (!aresetn) begin
            cmd_cnt = 0;
        end else begin
            if (cmd_out_wr) begin
                if (cmd_cnt < 8) cmd_log[cmd_cnt] = cmd_out[51:32];
                cmd_cnt++;
            end
            if (acc_start) acc_total++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {ddr_write_start, ddr_write_start_valid, write_buf_idx, ddr_write_finish_ready,
                           acc_start, acc_buf_idx, ddr_read_start, ddr_read_start_valid, read_buf_idx,
                           ddr_read_finish_ready, cmd_out_wr, timeout_err, odd_even_flag, busy}, 64'd0);
        chk({tag, "_cmd"}, cmd_out, 64'd0);
        chk({tag, "_cnt"}, frame_cnt, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; start_all = 1'b0; cont_mode = 1'b0; cmd_out_alf = 1'b0;
        ddr_write_start_ready = 1'b1; ddr_write_finish = 1'b1; ddr_write_finish_valid = 1'b1;
        ddr_read_start_ready = 1'b1; ddr_read_finish = 1'b1; ddr_read_finish_valid = 1'b1;
        acc_finish = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        aresetn = 1'b1;
        step();

        // Single frame, instant DDR engines, accelerator answers 5 cycles after acc_start.
        start_all = 1'b1; step(); start_all = 1'b0;
        chk("t2_c1_no_cmd", cmd_out_wr, 0);
        chk("t2_c1_busy", busy, 1);
        step();
        chk("t2_latency_cmd_wr", cmd_out_wr, 1);
        chk("t2_cmd_word", cmd_out, 64'h9000_0000_0000_0001);
        step();
        chk("t2_wr_req", {ddr_write_start, ddr_write_start_valid, ddr_write_finish_ready}, 3'b110);
        step();
        chk("t2_wr_wait", {ddr_write_start, ddr_write_finish_ready}, 2'b01);
`ifndef ACCEL_BYPASS_EN
        step(); step();
        chk("t2_acc_start", {acc_start, 2'(acc_buf_idx)}, 3'b100);
        repeat (5) step();
        acc_finish = 1'b1; step(); acc_finish = 1'b0;
`endif
        for (int i = 0; i < 30 && frame_cnt == 0; i++) step();
        chk("t2_frame_cnt", frame_cnt, 1);
        chk("t2_odd_even", odd_even_flag, 1);
        repeat (12) step();
        chk("t2_one_capture", cmd_cnt, 1);
        chk("t2_idle", {busy, frame_cnt[3:0]}, 5'b0_0001);
`ifndef ACCEL_BYPASS_EN
        chk("t2_acc_pulses", acc_total, 1);
`endif

        // Remote cmd FIFO almost full holds the writer in W_CMD.
        cmd_out_alf = 1'b1; acc_finish = 1'b1;
        start_all = 1'b1; step(); start_all = 1'b0;
        repeat (20) step();
        chk("t4_held_cmd_cnt", cmd_cnt, 1);
        chk("t4_held_outputs", {cmd_out_wr, ddr_write_start, busy}, 3'b001);
        chk("t4_wr_idx", write_buf_idx, 1);
        cmd_out_alf = 1'b0; #1;
        chk("t4_cmd_on_release", cmd_out_wr, 1);
        chk("t4_cmd_word", cmd_out, 64'h9000_0001_0000_0001);
        step();
        chk("t4_pulse_then_req", {cmd_out_wr, ddr_write_start}, 2'b01);
        for (int i = 0; i < 40 && frame_cnt < 2; i++) step();
        chk("t4_frame_cnt", frame_cnt, 2);
        chk("t4_odd_even", odd_even_flag, 0);

        // Reset while the writer sits in W_WAIT.
        ddr_write_finish = 1'b0;
        start_all = 1'b1; step(); start_all = 1'b0;
        for (int i = 0; i < 20 && !ddr_write_finish_ready; i++) step();
        chk("t1_in_wwait", {ddr_write_finish_ready, 2'(write_buf_idx)}, 3'b110);
        aresetn = 1'b0; #1;
        check_all_zero("t1_midreset");
        step();
        aresetn = 1'b1; ddr_write_finish = 1'b1;

        // Continuous capture with readout stuck: three captures fill the ring, then the writer stalls.
        cont_mode = 1'b1; ddr_read_finish = 1'b0;
        start_all = 1'b1; step(); start_all = 1'b0;
        repeat (60) step();
        chk("t3_capture_cnt", cmd_cnt, 3);
        chk("t3_capture_idx", {cmd_log[0], cmd_log[1], cmd_log[2]}, {20'd0, 20'd1, 20'd2});
        chk("t3_stalled", {2'(write_buf_idx), ddr_write_start, ddr_write_finish_ready}, 4'b0000);
        chk("t3_reader_wait", {2'(read_buf_idx), ddr_read_finish_ready}, 3'b001);
        chk("t3_rd_timeout", timeout_err, 3'b100);
        chk("t3_no_frames", frame_cnt, 0);
        ddr_read_finish = 1'b1;
        for (int i = 0; i < 40 && cmd_cnt < 4; i++) step();
        chk("t3_resume_cnt", cmd_cnt, 4);
        chk("t3_resume_idx", cmd_log[3], 0);
        chk("t3_sticky", timeout_err, 3'b100);
        aresetn = 1'b0; step(); aresetn = 1'b1;
        chk("t3_reset_clears_sticky", timeout_err, 0);

`ifndef ACCEL_BYPASS_EN
        // Accelerator never answers: sticky accel timeout, late finish still completes the frame.
        cont_mode = 1'b0; acc_finish = 1'b0;
        start_all = 1'b1; step(); start_all = 1'b0;
        for (int i = 0; i < 30 && !acc_start; i++) step();
        chk("t5_acc_start", acc_start, 1);
        repeat (10) step();
        chk("t5_no_timeout_yet", timeout_err, 0);
        repeat (10) step();
        chk("t5_acc_timeout", timeout_err, 3'b010);
        chk("t5_still_waiting", {frame_cnt[3:0], busy}, 5'b0000_1);
        acc_finish = 1'b1; step(); acc_finish = 1'b0;
        for (int i = 0; i < 30 && frame_cnt == 0; i++) step();
        chk("t5_late_finish", frame_cnt, 1);
        chk("t5_sticky", timeout_err, 3'b010);
`else
        // Accelerator removed: readout follows capture with acc_finish never driven.
        cont_mode = 1'b0; acc_finish = 1'b0;
        start_all = 1'b1; step(); start_all = 1'b0;
        for (int i = 0; i < 30 && frame_cnt == 0; i++) step();
        chk("t6_frame_cnt", frame_cnt, 1);
        chk("t6_no_acc_start", acc_total, 0);
        chk("t6_acc_outputs", {acc_start, 2'(acc_buf_idx), timeout_err}, 6'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
